// File: rtl/div_rem_pipelined.sv
// Pipelined RV32M divide unit (DIV/DIVU/REM/REMU): restoring division, BITS_PER_STAGE bits per stage.
// Define DIV_EXC_FLAGS_EN to expose the o_div_zero / o_overflow result flags.
module div_rem_pipelined #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_STAGE = 4,
    parameter int TAG_W          = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               i_valid,
    input  logic [1:0]         i_op,
    input  logic [WIDTH-1:0]   i_dividend,
    input  logic [WIDTH-1:0]   i_divisor,
    input  logic [TAG_W-1:0]   i_tag,
    output logic               o_valid,
    output logic [WIDTH-1:0]   o_result,
    output logic [TAG_W-1:0]   o_tag,
`ifdef DIV_EXC_FLAGS_EN
    output logic               o_div_zero,
    output logic               o_overflow,
`endif
    output logic               o_busy
);

    localparam int STAGES = WIDTH / BITS_PER_STAGE;
    localparam logic [1:0] SPEC_NONE = 2'b00;
    localparam logic [1:0] SPEC_DIV0 = 2'b01;
    localparam logic [1:0] SPEC_OVF  = 2'b10;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    generate
        if (WIDTH % BITS_PER_STAGE != 0) begin : g_param_check
            $error("div_rem_pipelined: WIDTH must be a multiple of BITS_PER_STAGE");
        end
    endgenerate

    typedef struct packed {
        logic             valid;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] dvd;
        logic [WIDTH-1:0] rem;
        logic [WIDTH-1:0] quo;
        logic [WIDTH-1:0] dvs;
        logic             q_neg;
        logic             r_neg;
        logic [1:0]       spec;
    } stage_t;

    stage_t in_stage;
    stage_t nxt  [STAGES];
    stage_t pipe [STAGES];
    stage_t last;

    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic             is_rem;
    logic             res_neg;
    logic [WIDTH-1:0] sel;
    logic [WIDTH-1:0] result;
    logic             busy;

    // Operand conditioning: magnitudes, result signs and the special-case code.
    always_comb begin
        is_signed = ~i_op[0];
        a_neg     = is_signed & i_dividend[WIDTH-1];
        b_neg     = is_signed & i_divisor[WIDTH-1];

        in_stage       = '0;
        in_stage.valid = i_valid;
        in_stage.op    = i_op;
        in_stage.tag   = i_tag;
        in_stage.dvd   = a_neg ? -i_dividend : i_dividend;
        in_stage.dvs   = b_neg ? -i_divisor : i_divisor;
        in_stage.q_neg = a_neg ^ b_neg;
        in_stage.r_neg = a_neg;
        if (i_divisor == '0)
            in_stage.spec = SPEC_DIV0;
        else if (is_signed && i_dividend == MOST_NEG && i_divisor == '1)
            in_stage.spec = SPEC_OVF;
        else
            in_stage.spec = SPEC_NONE;
    end

    function automatic stage_t step(input stage_t s);
        stage_t           t;
        logic [WIDTH:0]   trial;
        t = s;
        for (int i = 0; i < BITS_PER_STAGE; i++) begin
            trial = {t.rem, t.dvd[WIDTH-1]};
            if (trial >= {1'b0, t.dvs}) begin
                trial = trial - {1'b0, t.dvs};
                t.quo = {t.quo[WIDTH-2:0], 1'b1};
            end else begin
                t.quo = {t.quo[WIDTH-2:0], 1'b0};
            end
            t.rem = trial[WIDTH-1:0];
            t.dvd = {t.dvd[WIDTH-2:0], 1'b0};
        end
        return t;
    endfunction

    always_comb begin
        nxt[0] = step(in_stage);
        for (int k = 1; k < STAGES; k++)
            nxt[k] = step(pipe[k-1]);
    end

    // Reset wins over stall so in-flight operations are discarded even while frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++)
                pipe[k] <= '0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++)
                pipe[k] <= nxt[k];
        end
    end

    assign last = pipe[STAGES-1];

    always_comb begin
        is_rem  = last.op[1];
        sel     = is_rem ? last.rem : last.quo;
        res_neg = ~last.op[0] & (is_rem ? last.r_neg : last.q_neg);
        result  = res_neg ? -sel : sel;
        case (last.spec)
            SPEC_DIV0: if (!is_rem) result = '1;
            SPEC_OVF:  result = is_rem ? '0 : MOST_NEG;
            default:   ;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < STAGES; k++)
            busy = busy | pipe[k].valid;
    end

    assign o_valid  = last.valid;
    assign o_result = result;
    assign o_tag    = last.tag;
    assign o_busy   = busy;
`ifdef DIV_EXC_FLAGS_EN
    assign o_div_zero = last.valid & (last.spec == SPEC_DIV0);
    assign o_overflow = last.valid & (last.spec == SPEC_OVF);
`endif

endmodule

// File: tb/tb_div_rem_pipelined.sv
// Directed self-checking bench for div_rem_pipelined: expected results, tags and arrival cycles
// are queued at issue and compared when each result retires.
module tb_div_rem_pipelined;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        i_valid;
    logic [1:0]  i_op;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic [4:0]  i_tag;
    logic        o_valid;
    logic [31:0] o_result;
    logic [4:0]  o_tag;
    logic        o_busy;
`ifdef DIV_EXC_FLAGS_EN
    logic        o_div_zero;
    logic        o_overflow;
`endif

    div_rem_pipelined dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .i_valid    (i_valid),
        .i_op       (i_op),
        .i_dividend (i_dividend),
        .i_divisor  (i_divisor),
        .i_tag      (i_tag),
        .o_valid    (o_valid),
        .o_result   (o_result),
        .o_tag      (o_tag),
`ifdef DIV_EXC_FLAGS_EN
        .o_div_zero (o_div_zero),
        .o_overflow (o_overflow),
`endif
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  tag;
        logic        dz;
        logic        ov;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          cyc;
        logic        dz;
        logic        ov;
    } exp_t;

    // op: 0 DIV, 1 DIVU, 2 REM, 3 REMU
    vec_t dir_vecs [13] = '{
        '{2'd1, 32'd100,        32'd7,          32'd14,         5'd3,  1'b0, 1'b0},
        '{2'd3, 32'd100,        32'd7,          32'd2,          5'd4,  1'b0, 1'b0},
        '{2'd0, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   5'd5,  1'b0, 1'b0},
        '{2'd2, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   5'd6,  1'b0, 1'b0},
        '{2'd2, 32'd7,          32'hFFFFFFFE,   32'd1,          5'd7,  1'b0, 1'b0},
        '{2'd0, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   5'd8,  1'b0, 1'b1},
        '{2'd2, 32'h80000000,   32'hFFFFFFFF,   32'd0,          5'd9,  1'b0, 1'b1},
        '{2'd1, 32'h80000000,   32'hFFFFFFFF,   32'd0,          5'd10, 1'b0, 1'b0},
        '{2'd3, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   5'd11, 1'b0, 1'b0},
        '{2'd1, 32'd5,          32'd0,          32'hFFFFFFFF,   5'd12, 1'b1, 1'b0},
        '{2'd2, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   5'd13, 1'b1, 1'b0},
        '{2'd0, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   5'd14, 1'b1, 1'b0},
        '{2'd3, 32'd5,          32'd0,          32'd5,          5'd15, 1'b1, 1'b0}
    };

    vec_t stream_vecs [10] = '{
        '{2'd1, 32'd1000,       32'd10,         32'd100,        5'd16, 1'b0, 1'b0},
        '{2'd3, 32'd1000,       32'd7,          32'd6,          5'd17, 1'b0, 1'b0},
        '{2'd0, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   5'd18, 1'b0, 1'b0},
        '{2'd2, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   5'd19, 1'b0, 1'b0},
        '{2'd0, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   5'd20, 1'b0, 1'b0},
        '{2'd2, 32'd100,        32'hFFFFFFF9,   32'd2,          5'd21, 1'b0, 1'b0},
        '{2'd0, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         5'd22, 1'b0, 1'b0},
        '{2'd2, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE,   5'd23, 1'b0, 1'b0},
        '{2'd1, 32'hFFFFFFFF,   32'd3,          32'h55555555,   5'd24, 1'b0, 1'b0},
        '{2'd3, 32'hDEADBEEF,   32'h100,        32'hEF,         5'd25, 1'b0, 1'b0}
    };

    exp_t exp_q [$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] tag, input logic stl);
        @(posedge clk);
        #1;
        i_valid    = v;
        i_op       = op;
        i_dividend = a;
        i_divisor  = b;
        i_tag      = tag;
        stall      = stl;
    endtask

    // extra = stall cycles that will occur while this operation is in flight
    task automatic issueVec(input vec_t v, input int extra);
        applyStimulus(1'b1, v.op, v.a, v.b, v.tag, 1'b0);
        exp_q.push_back('{v.res, v.tag, cyc + 8 + extra, v.dz, v.ov});
    endtask

    task automatic idle();
        applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    endtask

    task automatic drainQueue(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++)
            idle();
        @(negedge clk);
        checkOutput(name, exp_q.size(), 0);
    endtask

    // Retirement monitor: a result retires on any non-stalled cycle with o_valid high.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && !stall && o_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_valid", o_valid, 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput($sformatf("tag_%0d", e.tag), o_tag, e.tag);
                checkOutput($sformatf("result_tag_%0d", e.tag), o_result, e.res);
                checkOutput($sformatf("arrival_tag_%0d", e.tag), cyc, e.cyc);
`ifdef DIV_EXC_FLAGS_EN
                checkOutput($sformatf("div_zero_tag_%0d", e.tag), o_div_zero, e.dz);
                checkOutput($sformatf("overflow_tag_%0d", e.tag), o_overflow, e.ov);
`endif
            end
        end
    end

    initial begin
        rst        = 1'b1;
        stall      = 1'b0;
        i_valid    = 1'b0;
        i_op       = 2'd0;
        i_dividend = '0;
        i_divisor  = '0;
        i_tag      = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_valid",  o_valid,  0);
        checkOutput("reset_busy",   o_busy,   0);
        checkOutput("reset_result", o_result, 0);
        checkOutput("reset_tag",    o_tag,    0);

        // Single DIVU alone to pin the 8-cycle latency, then the rest back-to-back.
        issueVec(dir_vecs[0], 0);
        drainQueue("drain_single");
        for (int k = 1; k < 13; k++)
            issueVec(dir_vecs[k], 0);
        drainQueue("drain_directed");

        for (int k = 0; k < 10; k++)
            issueVec(stream_vecs[k], 0);
        drainQueue("drain_stream");

        // Same stream with a 3-cycle stall after op 4; op 5 is presented but must not be taken.
        for (int k = 0; k < 5; k++)
            issueVec(stream_vecs[k], 3);
        repeat (3)
            applyStimulus(1'b1, stream_vecs[5].op, stream_vecs[5].a, stream_vecs[5].b,
                          stream_vecs[5].tag, 1'b1);
        for (int k = 5; k < 10; k++)
            issueVec(stream_vecs[k], 0);
        drainQueue("drain_stall_stream");

        // Reset with 5 ops in flight, asserted together with stall and a new valid input.
        for (int k = 0; k < 5; k++)
            applyStimulus(1'b1, stream_vecs[k].op, stream_vecs[k].a, stream_vecs[k].b,
                          stream_vecs[k].tag, 1'b0);
        @(negedge clk);
        checkOutput("busy_inflight", o_busy, 1);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        stall   = 1'b1;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        stall   = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
        checkOutput("flush_valid",  o_valid,  0);
        checkOutput("flush_busy",   o_busy,   0);
        checkOutput("flush_result", o_result, 0);
        checkOutput("flush_tag",    o_tag,    0);
        repeat (8) idle();
        @(negedge clk);
        checkOutput("busy_after_flush", o_busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
